tile_cmd_engine: RTL and testbench

- Bus-side command engine upstream of the tile renderer. It owns the renderer's tile-map write port.
- Accepts CPU register writes (single tile put with auto-increment cursor, rectangle fill, full-screen clear).
- Buffers puts in a FIFO and issues at most one tile-map write per cycle: tile_we, tile_addr, tile_data.
- The renderer consumes these writes into its 4800-entry, 6-bit tile array (80x60 tiles of 8x8 pixels).

---
 rtl/tile_cmd_pkg.sv | 23 ++
 rtl/tile_cmd_fifo.sv | 45 ++++
 rtl/tile_cmd_engine.sv | 189 ++++++++++++++++++
 tb/tb_tile_cmd_engine.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tile_cmd_pkg.sv
// Shared constants, register map and helpers for the tile command engine.
package tile_cmd_pkg;

   localparam int TILE_COLS  = 80;
   localparam int TILE_ROWS  = 60;
   localparam int TILE_COUNT = 4800;
   localparam int ADDR_W     = 13;

   localparam logic [2:0] REG_CURSOR = 3'd0;
   localparam logic [2:0] REG_PUT    = 3'd1;
   localparam logic [2:0] REG_SIZE   = 3'd2;
   localparam logic [2:0] REG_FILL   = 3'd3;
   localparam logic [2:0] REG_CLEAR  = 3'd4;
   localparam logic [2:0] REG_STATUS = 3'd5;

   typedef enum logic [1:0] {IDLE, FILL, CLEAR} state_t;

   // row*80 + col as (row<<6) + (row<<4) + col
   function automatic logic [ADDR_W-1:0] tile_index(input logic [5:0] row, input logic [6:0] col);
      return ({7'd0, row} << 6) + ({7'd0, row} << 4) + {6'd0, col};
   endfunction

endpackage

// File: rtl/tile_cmd_fifo.sv
// Synchronous FIFO with full/empty flags; a push while full is discarded.
module tile_cmd_fifo #(
   parameter int DEPTH = 16,
   parameter int WIDTH = 19
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] pop_data,
   output logic             full,
   output logic             empty
);
   localparam int PTR_W = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W:0]   wr_ptr;
   logic [PTR_W:0]   rd_ptr;
   logic             do_push;
   logic             do_pop;

   // Extra pointer bit distinguishes full from empty when indices match.
   assign empty    = (wr_ptr == rd_ptr);
   assign full     = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                     (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
   assign do_push  = push && !full;
   assign do_pop   = pop && !empty;
   assign pop_data = mem[rd_ptr[PTR_W-1:0]];

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + (PTR_W+1)'(1);
         if (do_pop)  rd_ptr <= rd_ptr + (PTR_W+1)'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[PTR_W-1:0]] <= push_data;
   end

endmodule

// File: rtl/tile_cmd_engine.sv
// Bus-side tile-map writer: cursor puts via FIFO, rectangle fill and full clear.
// Define TILE_CMD_VBLANK_GATE_EN to restrict tile writes to vblank cycles.
module tile_cmd_engine
   import tile_cmd_pkg::*;
#(
   parameter int FIFO_DEPTH = 16,
   parameter int ID_W       = 6
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            chipselect,
   input  logic            write,
   input  logic            read,
   input  logic [2:0]      address,
   input  logic [15:0]     writedata,
   output logic [15:0]     readdata,
   output logic            tile_we,
   output logic [12:0]     tile_addr,
   output logic [ID_W-1:0] tile_data,
   input  logic            vblank
);
   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [ID_W-1:0]   id;
   } fifo_entry_t;

   state_t            state, state_next;
   logic [12:0]       cursor;
   logic [7:0]        rect_w, rect_h;
   logic              overflow, reject;
   logic [6:0]        col, col_org, col_last;
   logic [5:0]        row, row_last;
   logic [12:0]       clear_addr;
   logic [ID_W-1:0]   fill_id;
   fifo_entry_t       push_entry, pop_entry;
   logic              fifo_full, fifo_empty, fifo_push, fifo_pop;
   logic              wr_en, rd_en, go, busy, cmd_ok, fill_start, clear_start;
   logic              issue;
   logic [12:0]       issue_addr;
   logic [ID_W-1:0]   issue_id;
   logic [5:0]        cur_row;
   logic [6:0]        cur_col;
   logic [8:0]        col_end, row_end;

`ifdef TILE_CMD_VBLANK_GATE_EN
   assign go = vblank;
`else
   logic unused_vblank;
   assign unused_vblank = vblank;
   assign go = 1'b1;
`endif

   assign wr_en  = chipselect && write;
   assign rd_en  = chipselect && read;
   assign busy   = (state != IDLE) || !fifo_empty;
   // Block commands are only taken with nothing queued, keeping program order.
   assign cmd_ok = (state == IDLE) && fifo_empty;
   assign fill_start  = wr_en && (address == REG_FILL) && cmd_ok &&
                        (rect_w != 8'd0) && (rect_h != 8'd0);
   assign clear_start = wr_en && (address == REG_CLEAR) && cmd_ok;

   assign cur_row = 6'(cursor / 13'(TILE_COLS));
   assign cur_col = 7'(cursor - tile_index(cur_row, 7'd0));
   assign col_end = {2'b0, cur_col} + {1'b0, rect_w} - 9'd1;
   assign row_end = {3'b0, cur_row} + {1'b0, rect_h} - 9'd1;

   assign push_entry = '{addr: cursor, id: writedata[ID_W-1:0]};
   assign fifo_push  = wr_en && (address == REG_PUT);

   tile_cmd_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH ($bits(fifo_entry_t))
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (fifo_push),
      .push_data (push_entry),
      .pop       (fifo_pop),
      .pop_data  (pop_entry),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   always_comb begin
      state_next = state;
      fifo_pop   = 1'b0;
      issue      = 1'b0;
      issue_addr = tile_index(row, col);
      issue_id   = fill_id;
      case (state)
         IDLE: begin
            if (fill_start)       state_next = FILL;
            else if (clear_start) state_next = CLEAR;
            else if (!fifo_empty && go) begin
               fifo_pop   = 1'b1;
               issue      = 1'b1;
               issue_addr = pop_entry.addr;
               issue_id   = pop_entry.id;
            end
         end
         FILL: begin
            if (go) begin
               issue = 1'b1;
               if (col == col_last && row == row_last) state_next = IDLE;
            end
         end
         CLEAR: begin
            if (go) begin
               issue      = 1'b1;
               issue_addr = clear_addr;
               if (clear_addr == 13'(TILE_COUNT-1)) state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         cursor    <= '0;
         rect_w    <= 8'd1;
         rect_h    <= 8'd1;
         overflow  <= 1'b0;
         reject    <= 1'b0;
         tile_we   <= 1'b0;
         tile_addr <= '0;
         tile_data <= '0;
      end else begin
         state   <= state_next;
         tile_we <= issue;
         if (issue) begin
            tile_addr <= issue_addr;
            tile_data <= issue_id;
         end
         if (wr_en) begin
            case (address)
               REG_CURSOR: if (writedata[12:0] < 13'(TILE_COUNT)) cursor <= writedata[12:0];
               REG_PUT: begin
                  if (fifo_full)                          overflow <= 1'b1;
                  else if (cursor == 13'(TILE_COUNT-1))   cursor   <= '0;
                  else                                    cursor   <= cursor + 13'd1;
               end
               REG_SIZE: begin
                  rect_w <= writedata[7:0];
                  rect_h <= writedata[15:8];
               end
               REG_FILL, REG_CLEAR: if (!cmd_ok) reject <= 1'b1;
               REG_STATUS: begin
                  overflow <= 1'b0;
                  reject   <= 1'b0;
               end
               default: ;
            endcase
         end
      end
   end

   // Iterator: clipping is folded into col_last/row_last so off-screen tiles cost no cycles.
   always_ff @(posedge clk) begin
      if (fill_start) begin
         col      <= cur_col;
         col_org  <= cur_col;
         row      <= cur_row;
         col_last <= (col_end > 9'(TILE_COLS-1)) ? 7'(TILE_COLS-1) : col_end[6:0];
         row_last <= (row_end > 9'(TILE_ROWS-1)) ? 6'(TILE_ROWS-1) : row_end[5:0];
         fill_id  <= writedata[ID_W-1:0];
      end else if (clear_start) begin
         clear_addr <= '0;
         fill_id    <= writedata[ID_W-1:0];
      end else if (issue && state == FILL) begin
         if (col == col_last) begin
            col <= col_org;
            row <= row + 6'd1;
         end else begin
            col <= col + 7'd1;
         end
      end else if (issue && state == CLEAR) begin
         clear_addr <= clear_addr + 13'd1;
      end
   end

   always_comb begin
      readdata = '0;
      if (rd_en && address == REG_STATUS)
         readdata = {12'd0, reject, overflow, fifo_full, busy};
   end

endmodule

// File: tb/tb_tile_cmd_engine.sv
// Directed bench for tile_cmd_engine: puts, wrap, fill/clip, clear, overflow, reset abort.
`timescale 1ns/1ps
module tb_tile_cmd_engine;
   localparam int ID_W = 6;

   logic            clk = 1'b0;
   logic            reset;
   logic            chipselect;
   logic            write;
   logic            read;
   logic [2:0]      address;
   logic [15:0]     writedata;
   logic [15:0]     readdata;
   logic            tile_we;
   logic [12:0]     tile_addr;
   logic [ID_W-1:0] tile_data;
   logic            vblank;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   typedef struct {
      int addr;
      int id;
      int cyc;
   } wr_rec_t;
   wr_rec_t wq[$];

   tile_cmd_engine #(.FIFO_DEPTH(16), .ID_W(ID_W)) dut (
      .clk        (clk),
      .reset      (reset),
      .chipselect (chipselect),
      .write      (write),
      .read       (read),
      .address    (address),
      .writedata  (writedata),
      .readdata   (readdata),
      .tile_we    (tile_we),
      .tile_addr  (tile_addr),
      .tile_data  (tile_data),
      .vblank     (vblank)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   always @(negedge clk) begin
      if (tile_we === 1'b1) wq.push_back('{addr: int'(tile_addr), id: int'(tile_data), cyc: cyc});
   end

   task automatic bus_wr(input logic [2:0] a, input logic [15:0] d);
      chipselect = 1'b1; write = 1'b1; address = a; writedata = d;
      @(posedge clk); #1;
      chipselect = 1'b0; write = 1'b0;
   endtask

   task automatic rd_status(output logic [15:0] v);
      chipselect = 1'b1; read = 1'b1; address = 3'd5;
      #1 v = readdata;
      chipselect = 1'b0; read = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      logic [15:0] s;
      reset = 1'b1;
      idle(3);
      checks++; if (tile_we !== 1'b0) begin errors++; $display("FAIL reset_we: got %b want 0", tile_we); end
      checks++; if (tile_addr !== 13'd0) begin errors++; $display("FAIL reset_addr: got %0d want 0", tile_addr); end
      checks++; if (tile_data !== 6'd0) begin errors++; $display("FAIL reset_data: got %0d want 0", tile_data); end
      rd_status(s);
      checks++; if (s !== 16'h0000) begin errors++; $display("FAIL reset_status: got %h want 0000", s); end
      reset = 1'b0;
      idle(1);
      wq.delete();
      bus_wr(3'd3, 16'd9);
      idle(4);
      checks++;
      if (wq.size() != 1 || wq[0].addr != 0 || wq[0].id != 9) begin
         errors++; $display("FAIL default_fill: got %0d writes (first addr %0d) want 1 write (0,9)",
                            wq.size(), (wq.size() > 0) ? wq[0].addr : -1);
      end
   endtask

   task automatic test_put_latency();
      int c0;
      wq.delete();
      bus_wr(3'd0, 16'd100);
      bus_wr(3'd1, 16'd23);
      c0 = cyc;
      bus_wr(3'd1, 16'd24);
      idle(4);
      checks++; if (wq.size() != 2) begin errors++; $display("FAIL put_count: got %0d want 2", wq.size()); end
      for (int i = 0; i < 2; i++) begin
         checks++;
         if (i >= wq.size() || wq[i].addr != 100 + i || wq[i].id != 23 + i || wq[i].cyc != c0 + 1 + i) begin
            errors++;
            $display("FAIL put_%0d: got (%0d,%0d,cyc %0d) want (%0d,%0d,cyc %0d)", i,
                     (i < wq.size()) ? wq[i].addr : -1, (i < wq.size()) ? wq[i].id : -1,
                     (i < wq.size()) ? wq[i].cyc : -1, 100 + i, 23 + i, c0 + 1 + i);
         end
      end
   endtask

   task automatic test_wrap();
      int ea[3] = '{4799, 0, 1};
      wq.delete();
      bus_wr(3'd0, 16'd4799);
      bus_wr(3'd1, 16'd5);
      bus_wr(3'd1, 16'd6);
      idle(3);
      bus_wr(3'd1, 16'd7);
      idle(3);
      checks++; if (wq.size() != 3) begin errors++; $display("FAIL wrap_count: got %0d want 3", wq.size()); end
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (i >= wq.size() || wq[i].addr != ea[i] || wq[i].id != 5 + i) begin
            errors++;
            $display("FAIL wrap_%0d: got (%0d,%0d) want (%0d,%0d)", i,
                     (i < wq.size()) ? wq[i].addr : -1, (i < wq.size()) ? wq[i].id : -1, ea[i], 5 + i);
         end
      end
   endtask

   task automatic test_fill();
      logic [15:0] s;
      int ea[4] = '{238, 239, 318, 319};
      wq.delete();
      bus_wr(3'd0, 16'd238);
      bus_wr(3'd2, 16'h0204);
      bus_wr(3'd3, 16'd12);
      rd_status(s);
      checks++; if (s !== 16'h0001) begin errors++; $display("FAIL fill_busy: got %h want 0001", s); end
      idle(6);
      checks++; if (wq.size() != 4) begin errors++; $display("FAIL fill_count: got %0d want 4", wq.size()); end
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (i >= wq.size() || wq[i].addr != ea[i] || wq[i].id != 12 || wq[i].cyc != wq[0].cyc + i) begin
            errors++;
            $display("FAIL fill_%0d: got (%0d,%0d) want (%0d,12) consecutive", i,
                     (i < wq.size()) ? wq[i].addr : -1, (i < wq.size()) ? wq[i].id : -1, ea[i]);
         end
      end
      rd_status(s);
      checks++; if (s !== 16'h0000) begin errors++; $display("FAIL fill_done: got %h want 0000", s); end
      wq.delete();
      bus_wr(3'd0, 16'd4798);
      bus_wr(3'd2, 16'h0305);
      bus_wr(3'd3, 16'd44);
      idle(8);
      checks++;
      if (wq.size() != 2 || wq[0].addr != 4798 || wq[1].addr != 4799 || wq[0].id != 44 || wq[1].id != 44) begin
         errors++; $display("FAIL fill_clip: got %0d writes (first %0d) want 2 writes 4798,4799 id 44",
                            wq.size(), (wq.size() > 0) ? wq[0].addr : -1);
      end
      wq.delete();
      bus_wr(3'd2, 16'h0100);
      bus_wr(3'd3, 16'd7);
      rd_status(s);
      checks++; if (s !== 16'h0000) begin errors++; $display("FAIL fill_zero_busy: got %h want 0000", s); end
      idle(4);
      checks++; if (wq.size() != 0) begin errors++; $display("FAIL fill_zero_writes: got %0d want 0", wq.size()); end
   endtask

   task automatic test_clear();
      logic [15:0] s;
      int bad;
      wq.delete();
      bus_wr(3'd4, 16'd0);
      bus_wr(3'd3, 16'd3);
      rd_status(s);
      checks++; if (s !== 16'h0009) begin errors++; $display("FAIL clear_reject: got %h want 0009", s); end
      bus_wr(3'd5, 16'd0);
      rd_status(s);
      checks++; if (s !== 16'h0001) begin errors++; $display("FAIL clear_sticky_clr: got %h want 0001", s); end
      idle(4810);
      checks++; if (wq.size() != 4800) begin errors++; $display("FAIL clear_count: got %0d want 4800", wq.size()); end
      bad = -1;
      for (int i = 0; i < 4800 && bad < 0; i++) begin
         if (i >= wq.size() || wq[i].addr != i || wq[i].id != 0 || wq[i].cyc != wq[0].cyc + i) bad = i;
      end
      checks++; if (bad >= 0) begin errors++; $display("FAIL clear_order: first bad index %0d want none", bad); end
      rd_status(s);
      checks++; if (s !== 16'h0000) begin errors++; $display("FAIL clear_done: got %h want 0000", s); end
   endtask

   task automatic test_overflow();
      logic [15:0] s;
      int bad;
      wq.delete();
      bus_wr(3'd0, 16'd10);
      bus_wr(3'd4, 16'd1);
      for (int i = 0; i < 17; i++) bus_wr(3'd1, 16'(20 + i));
      rd_status(s);
      checks++; if (s !== 16'h0007) begin errors++; $display("FAIL ovf_status: got %h want 0007", s); end
      idle(4830);
      checks++; if (wq.size() != 4816) begin errors++; $display("FAIL ovf_count: got %0d want 4816", wq.size()); end
      bad = -1;
      for (int i = 0; i < 16 && bad < 0; i++) begin
         if (4800 + i >= wq.size() || wq[4800+i].addr != 10 + i || wq[4800+i].id != 20 + i) bad = i;
      end
      checks++; if (bad >= 0) begin errors++; $display("FAIL ovf_queued: first bad entry %0d want none", bad); end
      wq.delete();
      bus_wr(3'd1, 16'd50);
      idle(3);
      checks++;
      if (wq.size() != 1 || wq[0].addr != 26 || wq[0].id != 50) begin
         errors++; $display("FAIL ovf_cursor: got %0d writes (addr %0d) want (26,50)",
                            wq.size(), (wq.size() > 0) ? wq[0].addr : -1);
      end
      rd_status(s);
      checks++; if (s !== 16'h0004) begin errors++; $display("FAIL ovf_sticky: got %h want 0004", s); end
      bus_wr(3'd5, 16'd0);
      rd_status(s);
      checks++; if (s !== 16'h0000) begin errors++; $display("FAIL ovf_clr: got %h want 0000", s); end
   endtask

`ifdef TILE_CMD_VBLANK_GATE_EN
   task automatic test_vblank();
      logic [15:0] s;
      int bad;
      vblank = 1'b0;
      wq.delete();
      bus_wr(3'd0, 16'd200);
      for (int i = 0; i < 17; i++) bus_wr(3'd1, 16'(i));
      rd_status(s);
      checks++; if (s !== 16'h0007) begin errors++; $display("FAIL vb_status: got %h want 0007", s); end
      idle(5);
      checks++; if (wq.size() != 0) begin errors++; $display("FAIL vb_gated: got %0d writes want 0", wq.size()); end
      vblank = 1'b1;
      idle(20);
      checks++; if (wq.size() != 16) begin errors++; $display("FAIL vb_count: got %0d want 16", wq.size()); end
      bad = -1;
      for (int i = 0; i < 16 && bad < 0; i++) begin
         if (i >= wq.size() || wq[i].addr != 200 + i || wq[i].id != i || wq[i].cyc != wq[0].cyc + i) bad = i;
      end
      checks++; if (bad >= 0) begin errors++; $display("FAIL vb_stream: first bad entry %0d want none", bad); end
      bus_wr(3'd5, 16'd0);
   endtask
`endif

   task automatic test_reset_mid_clear();
      logic [15:0] s;
      bit found;
      wq.delete();
      bus_wr(3'd4, 16'd2);
      found = 1'b0;
      for (int i = 0; i < 3000 && !found; i++) begin
         @(negedge clk);
         if (tile_we === 1'b1 && tile_addr == 13'd1000) found = 1'b1;
      end
      checks++; if (!found) begin errors++; $display("FAIL rst_wait: addr 1000 seen %0d want 1", found); end
      reset = 1'b1;
      @(posedge clk); #1;
      checks++; if (tile_we !== 1'b0) begin errors++; $display("FAIL rst_we: got %b want 0", tile_we); end
      rd_status(s);
      checks++; if (s !== 16'h0000) begin errors++; $display("FAIL rst_status: got %h want 0000", s); end
      checks++;
      if (wq.size() != 1001) begin errors++; $display("FAIL rst_abort: got %0d writes want 1001", wq.size()); end
      reset = 1'b0;
      idle(1);
      wq.delete();
      bus_wr(3'd1, 16'd33);
      idle(3);
      checks++;
      if (wq.size() != 1 || wq[0].addr != 0 || wq[0].id != 33) begin
         errors++; $display("FAIL rst_cursor: got %0d writes (addr %0d) want (0,33)",
                            wq.size(), (wq.size() > 0) ? wq[0].addr : -1);
      end
   endtask

   initial begin
      reset = 1'b1; chipselect = 1'b0; write = 1'b0; read = 1'b0;
      address = 3'd0; writedata = 16'd0; vblank = 1'b1;
      test_reset();
      test_put_latency();
      test_wrap();
      test_fill();
      test_clear();
      test_overflow();
`ifdef TILE_CMD_VBLANK_GATE_EN
      test_vblank();
`endif
      test_reset_mid_clear();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
